// File: rtl/ace_ps2_keymatrix.sv
// PS/2 keyboard front end for the Jupiter Ace: receives Set 2 scancode
// frames, keeps an 8x5 key matrix, and answers the CPU row select with
// active-low column bits.
module ace_ps2_keymatrix #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 6500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] rows,
  output logic [4:0] kbd,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]      r_clk_sync, r_dat_sync;
  logic [FW-1:0]   r_filt_cnt;
  logic            r_filt_clk;
  logic            w_fall, w_bit;
  state_t          r_state, w_state_next;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_parity;
  logic [TW-1:0]   r_to_cnt;
  logic            w_timeout, w_accept, w_reject;
  logic [7:0]      r_code;
  logic            r_code_valid, r_frame_err;
  logic            r_brk, r_ext;
  logic [2:0]      r_skip;
  logic [7:0][4:0] r_matrix;
  logic            w_key_hit;
  logic [2:0]      w_key_row, w_key_col;
  logic [4:0]      w_cols;

  // Key map lookup: returns {hit, row, col} for a byte and its E0 prefix.
  function automatic logic [6:0] key_lookup(input logic [7:0] b, input logic ext);
    logic [6:0] k;
    k = '0;
    if (ext) begin
      case (b)
        8'h14:   k = {1'b1, 3'd0, 3'd1};
        8'h5A:   k = {1'b1, 3'd6, 3'd0};
        default: k = '0;
      endcase
    end else begin
      case (b)
        8'h12, 8'h59: k = {1'b1, 3'd0, 3'd0};
        8'h14: k = {1'b1, 3'd0, 3'd1};
        8'h1A: k = {1'b1, 3'd0, 3'd2};
        8'h22: k = {1'b1, 3'd0, 3'd3};
        8'h21: k = {1'b1, 3'd0, 3'd4};
        8'h1C: k = {1'b1, 3'd1, 3'd0};
        8'h1B: k = {1'b1, 3'd1, 3'd1};
        8'h23: k = {1'b1, 3'd1, 3'd2};
        8'h2B: k = {1'b1, 3'd1, 3'd3};
        8'h34: k = {1'b1, 3'd1, 3'd4};
        8'h15: k = {1'b1, 3'd2, 3'd0};
        8'h1D: k = {1'b1, 3'd2, 3'd1};
        8'h24: k = {1'b1, 3'd2, 3'd2};
        8'h2D: k = {1'b1, 3'd2, 3'd3};
        8'h2C: k = {1'b1, 3'd2, 3'd4};
        8'h16: k = {1'b1, 3'd3, 3'd0};
        8'h1E: k = {1'b1, 3'd3, 3'd1};
        8'h26: k = {1'b1, 3'd3, 3'd2};
        8'h25: k = {1'b1, 3'd3, 3'd3};
        8'h2E: k = {1'b1, 3'd3, 3'd4};
        8'h45: k = {1'b1, 3'd4, 3'd0};
        8'h46: k = {1'b1, 3'd4, 3'd1};
        8'h3E: k = {1'b1, 3'd4, 3'd2};
        8'h3D: k = {1'b1, 3'd4, 3'd3};
        8'h36: k = {1'b1, 3'd4, 3'd4};
        8'h4D: k = {1'b1, 3'd5, 3'd0};
        8'h44: k = {1'b1, 3'd5, 3'd1};
        8'h43: k = {1'b1, 3'd5, 3'd2};
        8'h3C: k = {1'b1, 3'd5, 3'd3};
        8'h35: k = {1'b1, 3'd5, 3'd4};
        8'h5A: k = {1'b1, 3'd6, 3'd0};
        8'h4B: k = {1'b1, 3'd6, 3'd1};
        8'h42: k = {1'b1, 3'd6, 3'd2};
        8'h3B: k = {1'b1, 3'd6, 3'd3};
        8'h33: k = {1'b1, 3'd6, 3'd4};
        8'h29: k = {1'b1, 3'd7, 3'd0};
        8'h3A: k = {1'b1, 3'd7, 3'd1};
        8'h31: k = {1'b1, 3'd7, 3'd2};
        8'h32: k = {1'b1, 3'd7, 3'd3};
        8'h2A: k = {1'b1, 3'd7, 3'd4};
        default: k = '0;
      endcase
    end
    return k;
  endfunction

  // Two-flop synchronisers for the asynchronous PS/2 lines (idle high).
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values and the shift chain really is two stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2clk};
      r_dat_sync <= {r_dat_sync[0], ps2data};
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  assign w_bit  = r_dat_sync[1];
  assign w_fall = r_filt_clk & ~r_clk_sync[1] & (r_filt_cnt == FILT_LAST);

  // Glitch filter on the synchronised PS/2 clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
      r_filt_clk <= 1'b1;
    end else if (r_clk_sync[1] == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FILT_LAST) begin
      r_filt_clk <= r_clk_sync[1];
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Receiver next state, frame accept/reject and timeout decisions.
  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_timeout    = 1'b0;
    if ((r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST)) begin
      w_timeout    = 1'b1;
      w_state_next = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_bit) w_state_next = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: w_state_next = S_STOP;
        S_STOP: begin
          w_state_next = S_IDLE;
          if (w_bit && (^{r_shift, r_parity})) w_accept = 1'b1;
          else                                 w_reject = 1'b1;
        end
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Receiver datapath: shift register, bit counter, idle timer and strobes.
  // NOTE: the key matrix and all decoder state are reset explicitly; a
  // power-up matrix with random pressed keys would be visible to the CPU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= w_accept;
      r_frame_err  <= w_reject | w_timeout;
      if (w_accept) r_code <= r_shift;
      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_fall && (r_state == S_DATA)) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_fall && (r_state == S_PARITY)) r_parity <= w_bit;
      if ((r_state == S_IDLE) || w_fall || w_timeout) r_to_cnt <= '0;
      else                                            r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign {w_key_hit, w_key_row, w_key_col} = key_lookup(r_code, r_ext);

  // Scancode decoder: prefix flags, Pause swallowing and matrix updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_brk    <= 1'b0;
      r_ext    <= 1'b0;
      r_skip   <= '0;
      r_matrix <= '0;
    end else if (r_code_valid) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 1'b1;
      end else begin
        case (r_code)
          8'hF0: r_brk  <= 1'b1;
          8'hE0: r_ext  <= 1'b1;
          8'hE1: r_skip <= 3'd7;
          8'hAA, 8'hFC, 8'h00, 8'hFF: begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
          end
          default: begin
            if (w_key_hit) r_matrix[w_key_row][w_key_col] <= ~r_brk;
            r_brk <= 1'b0;
            r_ext <= 1'b0;
          end
        endcase
      end
    end
  end

  // Wired-OR column read: every selected (low) row contributes its keys.
  always_comb begin
    w_cols = '0;
    for (int r = 0; r < 8; r++) begin
      if (!rows[r]) w_cols = w_cols | r_matrix[r];
    end
  end

  assign kbd        = ~w_cols;
  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ace_ps2_keymatrix.sv
// Self-checking bench for ace_ps2_keymatrix: PS/2 frames are driven bit by
// bit, expected strobes go into a scoreboard queue checked by a monitor, and
// the key matrix is probed through the row-select port.
module tb_ace_ps2_keymatrix;

  localparam int TIMEOUT = 6500;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       ps2clk  = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] rows    = 8'hFF;
  logic [4:0] kbd;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  ace_ps2_keymatrix #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2clk     (ps2clk),
    .ps2data    (ps2data),
    .rows       (rows),
    .kbd        (kbd),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks    = 0;
  int         n_fail      = 0;
  logic [7:0] model_code  = 8'h00;
  logic       prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (code_valid || frame_err) begin
      check("strobe_exclusive", {31'b0, code_valid & frame_err}, 32'd0);
      check("strobe_one_cycle", {31'b0, prev_strobe}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b code=%0h, expected none",
                 code_valid, frame_err, code);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {31'b0, frame_err}, {31'b0, mon_e.is_err});
        check("strobe_code", {24'b0, code}, {24'b0, mon_e.code});
      end
    end
    prev_strobe <= code_valid | frame_err;
  end

  // One PS/2 bit: data set while clock is high, then a low pulse.
  task automatic ps2_bit(input logic b);
    ps2data = b;
    repeat (10) @(negedge clk);
    ps2clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
  endtask

  task automatic send_ok(input logic [7:0] b);
    exp_t e;
    e.is_err   = 1'b0;
    e.code     = b;
    model_code = b;
    exp_q.push_back(e);
    send_byte(b, 1'b0);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = model_code;
    exp_q.push_back(e);
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic probe(input string name, input logic [7:0] r, input logic [4:0] exp);
    rows = r;
    #1;
    check(name, {27'b0, kbd}, {27'b0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held across a whole frame: nothing may come out.
    rst_n = 1'b0;
    send_byte(8'h1C, 1'b0);
    probe("reset_kbd", 8'h00, 5'b11111);
    check("reset_code", {24'b0, code}, 32'h00);
    check("reset_valid", {31'b0, code_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Make then break of A (row 1 col 0).
    send_ok(8'h1C);
    probe("make_A", 8'hFD, 5'b11110);
    send_ok(8'hF0);
    send_ok(8'h1C);
    probe("break_A", 8'hFD, 5'b11111);
    drain("make_break_drain");

    // Extended SymShift plus Space, multi-row select.
    send_ok(8'hE0);
    send_ok(8'h14);
    send_ok(8'h29);
    probe("multi_row", 8'h7E, 5'b11100);
    probe("row0_only", 8'hFE, 5'b11101);
    probe("row7_only", 8'h7F, 5'b11110);
    probe("no_row", 8'hFF, 5'b11111);
    drain("ext_drain");

    // Parity error on Z: code and matrix must be untouched.
    expect_err();
    send_byte(8'h1A, 1'b1);
    drain("parity_drain");
    check("parity_code", {24'b0, code}, 32'h29);
    probe("parity_matrix", 8'hFE, 5'b11101);

    // Timeout after four data bits, then a clean Q.
    expect_err();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    repeat (TIMEOUT + 100) @(negedge clk);
    drain("timeout_drain");
    send_ok(8'h15);
    probe("after_timeout_Q", 8'hFB, 5'b11110);

    // Release SymShift and Space, then the Pause sequence.
    send_ok(8'hE0);
    send_ok(8'hF0);
    send_ok(8'h14);
    send_ok(8'hF0);
    send_ok(8'h29);
    send_ok(8'hE1);
    send_ok(8'h14);
    send_ok(8'h77);
    send_ok(8'hE1);
    send_ok(8'hF0);
    send_ok(8'h14);
    send_ok(8'hF0);
    send_ok(8'h77);
    probe("pause_symshift", 8'hFE, 5'b11111);
    probe("pause_space", 8'h7F, 5'b11111);

    // Shared Shift bit: two makes, one break clears it.
    send_ok(8'h12);
    send_ok(8'h59);
    probe("shift_down", 8'hFE, 5'b11110);
    send_ok(8'hF0);
    send_ok(8'h12);
    probe("shift_up", 8'hFE, 5'b11111);

    // Unlisted extended code changes nothing.
    send_ok(8'hE0);
    send_ok(8'h1C);
    probe("ext_unmapped", 8'hFD, 5'b11111);
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
